// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD text layer: grid defaults, blank character,
// arbiter state encoding and the cell index helper.
package lcd_pkg;

    localparam int GRID_COLUMNS    = 40;
    localparam int GRID_ROWS       = 15;
    localparam int GRID_CHAR_WIDTH = 7;
    localparam int GRID_ADDR_WIDTH = 10;

    localparam logic [6:0] CHAR_SPACE = 7'h20;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } lcd_state_t;

    // Linear cell index, wide enough for any 7-bit column / 6-bit row pair.
    function automatic logic [12:0] cell_index(input logic [6:0] column,
                                               input logic [5:0] row,
                                               input int         columns);
        return 13'(row) * 13'(columns) + 13'(column);
    endfunction

endpackage

// File: rtl/text_ram.sv
// Single-port character RAM with synchronous read. The read register only
// updates on read cycles, so the last looked-up character stays on rdata.
module text_ram #(
    parameter int DEPTH      = 600,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 7
) (
    input  logic                  clock,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/lcd_text_arbiter.sv
// Shares the character RAM between display lookups (highest priority), the
// clear sweep and host writes; one RAM operation per cycle.
module lcd_text_arbiter
    import lcd_pkg::*;
#(
    parameter int COLUMNS       = GRID_COLUMNS,
    parameter int ROWS          = GRID_ROWS,
    parameter int CHAR_WIDTH    = GRID_CHAR_WIDTH,
    parameter int ADDR_WIDTH    = GRID_ADDR_WIDTH,
    parameter bit POWERUP_CLEAR = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  disp_req,
    input  logic [6:0]            disp_column,
    input  logic [5:0]            disp_row,
    output logic                  disp_valid,
    output logic [CHAR_WIDTH-1:0] disp_char,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [6:0]            wr_column,
    input  logic [5:0]            wr_row,
    input  logic [CHAR_WIDTH-1:0] wr_char,
    input  logic                  clear_start,
    output logic                  busy,
    output logic                  clear_done,
    output logic                  wr_dropped
);

    localparam int                    CELLS      = COLUMNS * ROWS;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(CELLS - 1);
    localparam logic [CHAR_WIDTH-1:0] BLANK      = CHAR_WIDTH'(CHAR_SPACE);
    localparam lcd_state_t            RESET_STATE = POWERUP_CLEAR ? CLEAR : IDLE;

    lcd_state_t            state, state_next;
    logic [ADDR_WIDTH-1:0] clear_addr, clear_addr_next;
    logic                  disp_from_ram;

    logic                  disp_in_range, wr_in_range;
    logic [ADDR_WIDTH-1:0] disp_addr, wr_addr;
    logic                  wr_accept;

    logic                  ram_en, ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [CHAR_WIDTH-1:0] ram_wdata, ram_rdata;

    assign disp_in_range = (disp_column < 7'(COLUMNS)) && (disp_row < 6'(ROWS));
    assign wr_in_range   = (wr_column < 7'(COLUMNS)) && (wr_row < 6'(ROWS));
    assign disp_addr     = ADDR_WIDTH'(cell_index(disp_column, disp_row, COLUMNS));
    assign wr_addr       = ADDR_WIDTH'(cell_index(wr_column, wr_row, COLUMNS));

    assign busy      = (state == CLEAR);
    assign wr_ready  = (state == IDLE) && !disp_req && !clear_start;
    assign wr_accept = wr_valid && wr_ready;

    // Out-of-range lookups and the reset value both present a blank cell.
    assign disp_char = disp_from_ram ? ram_rdata : BLANK;

    always_comb begin
        state_next      = state;
        clear_addr_next = clear_addr;
        clear_done      = 1'b0;
        ram_en          = 1'b0;
        ram_we          = 1'b0;
        ram_addr        = '0;
        ram_wdata       = BLANK;

        if (disp_req) begin
            ram_en   = disp_in_range;
            ram_addr = disp_addr;
        end

        case (state)
            IDLE: begin
                if (clear_start) begin
                    state_next      = CLEAR;
                    clear_addr_next = '0;
                end else if (wr_accept && wr_in_range) begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = wr_addr;
                    ram_wdata = wr_char;
                end
            end
            CLEAR: begin
                if (!disp_req) begin
                    ram_en   = 1'b1;
                    ram_we   = 1'b1;
                    ram_addr = clear_addr;
                    if (clear_addr == LAST_ADDR) begin
                        clear_done = 1'b1;
                        state_next = IDLE;
                    end else begin
                        clear_addr_next = clear_addr + ADDR_WIDTH'(1);
                    end
                end
            end
            default: state_next = RESET_STATE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= RESET_STATE;
            clear_addr    <= '0;
            disp_valid    <= 1'b0;
            disp_from_ram <= 1'b0;
            wr_dropped    <= 1'b0;
        end else begin
            state      <= state_next;
            clear_addr <= clear_addr_next;
            disp_valid <= disp_req;
            if (disp_req) begin
                disp_from_ram <= disp_in_range;
            end
            if (wr_accept && !wr_in_range) begin
                wr_dropped <= 1'b1;
            end
        end
    end

    text_ram #(
        .DEPTH      (CELLS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (CHAR_WIDTH)
    ) u_text_ram (
        .clock (clock),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_lcd_text_arbiter.sv
// Directed bench for lcd_text_arbiter: power-up clear, display priority,
// range checks, clear/write collision, starvation and mid-clear reset.
module tb_lcd_text_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       disp_req = 1'b0;
    logic [6:0] disp_column = '0;
    logic [5:0] disp_row = '0;
    logic       disp_valid;
    logic [6:0] disp_char;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [6:0] wr_column = '0;
    logic [5:0] wr_row = '0;
    logic [6:0] wr_char = '0;
    logic       clear_start = 1'b0;
    logic       busy;
    logic       clear_done;
    logic       wr_dropped;

    int n_cmp = 0;
    int n_err = 0;

    lcd_text_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .disp_req    (disp_req),
        .disp_column (disp_column),
        .disp_row    (disp_row),
        .disp_valid  (disp_valid),
        .disp_char   (disp_char),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_column   (wr_column),
        .wr_row      (wr_row),
        .wr_char     (wr_char),
        .clear_start (clear_start),
        .busy        (busy),
        .clear_done  (clear_done),
        .wr_dropped  (wr_dropped)
    );

    always #5 clock = ~clock;

    // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Lookup followed by a gap cycle; returns what the DUT shows one cycle later.
    task automatic read_cell(input int col, input int row,
                             output logic [6:0] ch, output logic v);
        tick();
        disp_req    = 1'b1;
        disp_column = 7'(col);
        disp_row    = 6'(row);
        tick();
        disp_req = 1'b0;
        #1;
        v  = disp_valid;
        ch = disp_char;
    endtask

    // Starts in a cycle already in CLEAR; counts CLEAR cycles and the clear_done cycle.
    task automatic measure_clear(output int busy_n, output int done_at, output int done_n);
        busy_n  = 0;
        done_at = 0;
        done_n  = 0;
        for (int i = 0; i < 2000; i++) begin
            #1;
            if (!busy) break;
            busy_n++;
            if (clear_done) begin
                done_n++;
                done_at = busy_n;
            end
            tick();
        end
    endtask

    task automatic write_cell(input int col, input int row, input logic [6:0] ch);
        tick();
        wr_valid  = 1'b1;
        wr_column = 7'(col);
        wr_row    = 6'(row);
        wr_char   = ch;
        #1;
        n_cmp++;
        if (wr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL write_ready(%0d,%0d): got %b expected 1", col, row, wr_ready);
        end
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        int busy_n, done_at, done_n, bad, bad_valid;
        logic [6:0] ch;
        logic v;
        tick();
        tick();
        #1;
        n_cmp++;
        if ({busy, disp_valid, clear_done, wr_dropped, wr_ready} !== 5'b10000) begin
            n_err++;
            $display("FAIL reset_flags: got busy/valid/done/drop/ready=%b expected 10000",
                     {busy, disp_valid, clear_done, wr_dropped, wr_ready});
        end
        n_cmp++;
        if (disp_char !== 7'h20) begin
            n_err++;
            $display("FAIL reset_char: got %h expected 20", disp_char);
        end
        tick();
        reset = 1'b0;
        measure_clear(busy_n, done_at, done_n);
        n_cmp++;
        if (busy_n != 600) begin
            n_err++;
            $display("FAIL powerup_busy_cycles: got %0d expected 600", busy_n);
        end
        n_cmp++;
        if (done_at != 600 || done_n != 1) begin
            n_err++;
            $display("FAIL powerup_done: got cycle %0d count %0d expected cycle 600 count 1",
                     done_at, done_n);
        end
        bad = 0;
        bad_valid = 0;
        for (int r = 0; r < 15; r++) begin
            for (int c = 0; c < 40; c++) begin
                read_cell(c, r, ch, v);
                if (ch !== 7'h20) bad++;
                if (v !== 1'b1) bad_valid++;
            end
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL cleared_cells: got %0d non-blank cells expected 0", bad);
        end
        n_cmp++;
        if (bad_valid != 0) begin
            n_err++;
            $display("FAIL cleared_valid: got %0d missing valid pulses expected 0", bad_valid);
        end
    endtask

    task automatic test_display_priority();
        tick();
        disp_req    = 1'b1;
        disp_column = 7'd0;
        disp_row    = 6'd0;
        wr_valid    = 1'b1;
        wr_column   = 7'd3;
        wr_row      = 6'd2;
        wr_char     = 7'h41;
        #1;
        n_cmp++;
        if (wr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ready_during_req: got %b expected 0", wr_ready);
        end
        tick();
        disp_req = 1'b0;
        #1;
        n_cmp++;
        if (wr_ready !== 1'b1 || disp_valid !== 1'b1 || disp_char !== 7'h20) begin
            n_err++;
            $display("FAIL gap_cycle: got ready=%b valid=%b char=%h expected 1 1 20",
                     wr_ready, disp_valid, disp_char);
        end
        tick();
        wr_valid    = 1'b0;
        disp_req    = 1'b1;
        disp_column = 7'd3;
        disp_row    = 6'd2;
        #1;
        n_cmp++;
        if (disp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL valid_latency: got %b expected 0 in request cycle", disp_valid);
        end
        tick();
        disp_req = 1'b0;
        #1;
        n_cmp++;
        if (disp_valid !== 1'b1 || disp_char !== 7'h41) begin
            n_err++;
            $display("FAIL read_after_write: got valid=%b char=%h expected 1 41",
                     disp_valid, disp_char);
        end
    endtask

    task automatic test_out_of_range();
        logic [6:0] ch;
        logic v;
        #1;
        n_cmp++;
        if (wr_dropped !== 1'b0) begin
            n_err++;
            $display("FAIL dropped_initial: got %b expected 0", wr_dropped);
        end
        write_cell(40, 0, 7'h55);
        #1;
        n_cmp++;
        if (wr_dropped !== 1'b1) begin
            n_err++;
            $display("FAIL dropped_column: got %b expected 1", wr_dropped);
        end
        write_cell(0, 15, 7'h56);
        write_cell(39, 14, 7'h5A);
        #1;
        n_cmp++;
        if (wr_dropped !== 1'b1) begin
            n_err++;
            $display("FAIL dropped_sticky: got %b expected 1", wr_dropped);
        end
        read_cell(0, 0, ch, v);
        n_cmp++;
        if (ch !== 7'h20 || v !== 1'b1) begin
            n_err++;
            $display("FAIL cell_0_0: got %h valid %b expected 20 1", ch, v);
        end
        read_cell(0, 1, ch, v);
        n_cmp++;
        if (ch !== 7'h20) begin
            n_err++;
            $display("FAIL cell_0_1_alias: got %h expected 20", ch);
        end
        read_cell(39, 14, ch, v);
        n_cmp++;
        if (ch !== 7'h5A) begin
            n_err++;
            $display("FAIL cell_39_14: got %h expected 5a", ch);
        end
        read_cell(40, 0, ch, v);
        n_cmp++;
        if (ch !== 7'h20 || v !== 1'b1) begin
            n_err++;
            $display("FAIL lookup_out_of_range: got %h valid %b expected 20 1", ch, v);
        end
    endtask

    task automatic test_clear_vs_write();
        int n, done_at, ready_at;
        logic [6:0] ch;
        logic v;
        tick();
        clear_start = 1'b1;
        wr_valid    = 1'b1;
        wr_column   = 7'd5;
        wr_row      = 6'd5;
        wr_char     = 7'h42;
        #1;
        n_cmp++;
        if (wr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ready_with_clear_start: got %b expected 0", wr_ready);
        end
        tick();
        clear_start = 1'b0;
        n = 0;
        done_at = 0;
        ready_at = 0;
        for (int i = 0; i < 2000; i++) begin
            #1;
            n++;
            if (clear_done) done_at = n;
            if (wr_ready) begin
                ready_at = n;
                break;
            end
            tick();
        end
        n_cmp++;
        if (done_at != 600 || ready_at != 601) begin
            n_err++;
            $display("FAIL clear_then_write: got done %0d ready %0d expected 600 601",
                     done_at, ready_at);
        end
        tick();
        wr_valid = 1'b0;
        read_cell(5, 5, ch, v);
        n_cmp++;
        if (ch !== 7'h42) begin
            n_err++;
            $display("FAIL write_after_clear: got %h expected 42", ch);
        end
        read_cell(39, 14, ch, v);
        n_cmp++;
        if (ch !== 7'h20) begin
            n_err++;
            $display("FAIL cleared_39_14: got %h expected 20", ch);
        end
    endtask

    task automatic test_starvation();
        int n_valid, n_busy, n_done, done_at, n;
        tick();
        clear_start = 1'b1;
        disp_req    = 1'b1;
        disp_column = 7'd1;
        disp_row    = 6'd0;
        tick();
        clear_start = 1'b0;
        n_valid = 0;
        n_busy = 0;
        n_done = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (disp_valid) n_valid++;
            if (busy) n_busy++;
            if (clear_done) n_done++;
            tick();
        end
        disp_req = 1'b0;
        n_cmp++;
        if (n_valid != 100 || n_busy != 100 || n_done != 0) begin
            n_err++;
            $display("FAIL starved_clear: got valid %0d busy %0d done %0d expected 100 100 0",
                     n_valid, n_busy, n_done);
        end
        n = 0;
        done_at = 0;
        for (int i = 0; i < 2000; i++) begin
            clear_start = (i == 300);
            #1;
            n++;
            if (clear_done) begin
                done_at = n;
                break;
            end
            tick();
        end
        clear_start = 1'b0;
        n_cmp++;
        if (done_at != 600) begin
            n_err++;
            $display("FAIL clear_after_release: got %0d expected 600", done_at);
        end
    endtask

    task automatic test_reset_mid_clear();
        int busy_n, done_at, done_n;
        logic [6:0] ch;
        logic v;
        write_cell(39, 14, 7'h43);
        tick();
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int i = 0; i < 300; i++) tick();
        disp_req    = 1'b1;
        disp_column = 7'd39;
        disp_row    = 6'd14;
        tick();
        disp_req = 1'b0;
        #1;
        n_cmp++;
        if (disp_valid !== 1'b1 || disp_char !== 7'h43 || busy !== 1'b1 || wr_dropped !== 1'b1) begin
            n_err++;
            $display("FAIL before_reset: got valid=%b char=%h busy=%b drop=%b expected 1 43 1 1",
                     disp_valid, disp_char, busy, wr_dropped);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (disp_valid !== 1'b0 || disp_char !== 7'h20 || wr_dropped !== 1'b0 ||
            clear_done !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset: got valid=%b char=%h drop=%b done=%b busy=%b expected 0 20 0 0 1",
                     disp_valid, disp_char, wr_dropped, clear_done, busy);
        end
        tick();
        tick();
        reset = 1'b0;
        measure_clear(busy_n, done_at, done_n);
        n_cmp++;
        if (busy_n != 600 || done_at != 600 || done_n != 1) begin
            n_err++;
            $display("FAIL restart_clear: got busy %0d done %0d/%0d expected 600 600/1",
                     busy_n, done_at, done_n);
        end
        read_cell(39, 14, ch, v);
        n_cmp++;
        if (ch !== 7'h20) begin
            n_err++;
            $display("FAIL restart_cleared_cell: got %h expected 20", ch);
        end
    endtask

    initial begin
        test_reset();
        test_display_priority();
        test_out_of_range();
        test_clear_vs_write();
        test_starvation();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
